vc_buffer_arbiter: RTL

- Stage directly downstream of the initial-logic block (main FIFO, pop control, VC demux).
- Absorbs the per-VC push streams into two small VC FIFOs.
- Returns pause_vc0/pause_vc1 back upstream as flow control.
- Arbitrates one word per cycle toward the destination stage, with strict priority VC0 over VC1, gated by per-destination pause.

---
 rtl/vc_buffer_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vc_buffer_arbiter.sv
// vc_buffer_arbiter
//   Buffers the two per-VC push streams coming out of the VC demux in small
//   FIFOs, returns almost-full backpressure upstream, and forwards one word
//   per cycle downstream. VC0 has strict priority over VC1. A VC may pop only
//   when the destination selected by its head word (bit 4) is not paused.
// Ports:
//   clk, reset                    clock, async active-low reset
//   data_in_vcN, push_vcN         upstream write streams
//   pause_d0, pause_d1            downstream destination backpressure
//   pause_vcN                     upstream backpressure (registered count)
//   data_out, valid_out           arbitrated output word (registered)
//   empty_vcN, error_vcN          FIFO empty / sticky overflow flags

// Single VC FIFO. The count is one bit wider than the pointers so that
// full (count == depth) is distinct from empty.
module vc_fifo #(
  parameter int data_width     = 6,
  parameter int address_width  = 2,
  parameter int almost_full_th = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [data_width-1:0] data_in,
  input  logic                  pop,
  output logic [data_width-1:0] head,
  output logic                  empty,
  output logic                  pause,
  output logic                  error
);
  localparam int depth = 1 << address_width;

  logic [address_width-1:0] wr_ptr, rd_ptr;
  logic [address_width:0]   count;
  logic [data_width-1:0]    mem [depth];
  logic                     full, accept;

  assign full   = (count == (address_width+1)'(depth));
  // A push into a full FIFO is only taken when the same edge frees a slot.
  assign accept = push && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      error  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
      if (push && !accept)     error <= 1'b1;
    end
  end

  // Storage is not reset; resetting the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= data_in;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign pause = (count >= (address_width+1)'(almost_full_th));
endmodule

module vc_buffer_arbiter #(
  parameter int data_width     = 6,
  parameter int address_width  = 2,
  parameter int almost_full_th = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] data_in_vc0,
  input  logic                  push_vc0,
  input  logic [data_width-1:0] data_in_vc1,
  input  logic                  push_vc1,
  input  logic                  pause_d0,
  input  logic                  pause_d1,
  output logic                  pause_vc0,
  output logic                  pause_vc1,
  output logic [data_width-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty_vc0,
  output logic                  empty_vc1,
  output logic                  error_vc0,
  output logic                  error_vc1
);
  localparam int num_vc   = 2;
  localparam int dest_bit = 4;

  logic [num_vc-1:0][data_width-1:0] din, head;
  logic [num_vc-1:0] push, pop, elig, empty, pause, error;

  assign din  = {data_in_vc1, data_in_vc0};
  assign push = {push_vc1, push_vc0};

  for (genvar v = 0; v < num_vc; v++) begin : g_vc
    vc_fifo #(
      .data_width    (data_width),
      .address_width (address_width),
      .almost_full_th(almost_full_th)
    ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (push[v]),
      .data_in(din[v]),
      .pop    (pop[v]),
      .head   (head[v]),
      .empty  (empty[v]),
      .pause  (pause[v]),
      .error  (error[v])
    );
  end

  // Eligibility uses only registered FIFO state plus the live destination
  // pauses, so a word becomes poppable the cycle after it was written.
  always_comb begin
    elig = '0;
    for (int v = 0; v < num_vc; v++)
      elig[v] = !empty[v] && !(head[v][dest_bit] ? pause_d1 : pause_d0);
  end

  // Strict priority; a blocked VC0 head does not block VC1.
  assign pop[0] = elig[0];
  assign pop[1] = elig[1] && !elig[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= |pop;
      if (pop[0])      data_out <= head[0];
      else if (pop[1]) data_out <= head[1];
    end
  end

  assign {empty_vc1, empty_vc0} = empty;
  assign {pause_vc1, pause_vc0} = pause;
  assign {error_vc1, error_vc0} = error;
endmodule
